// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Leading-zero blanking is enabled by defining BIN2BCD_LEADING_BLANK_EN.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned BCD_DIGITS      = 4;
  localparam int unsigned NIB_W           = 4;
  localparam logic [3:0]  BLANK_CODE      = 4'hF;
  localparam int unsigned DEFAULT_MAX_VAL = 9999;

  // Displayed digit set, leftmost digit in the most significant nibble
  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd_t;

  // Replace leading zero digits with the blank code; the ones digit always shows
  function automatic bcd_t blank_leading(bcd_t v);
    bcd_t r;
    r = v;
    if (v.d3 == 4'd0) begin
      r.d3 = BLANK_CODE;
      if (v.d2 == 4'd0) begin
        r.d2 = BLANK_CODE;
        if (v.d1 == 4'd0) r.d1 = BLANK_CODE;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a requester and the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned BIN_W = 14
);
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic [3:0]       bcd0;
  logic [3:0]       bcd1;
  logic [3:0]       bcd2;
  logic [3:0]       bcd3;
  logic             ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd0, bcd1, bcd2, bcd3, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd0, bcd1, bcd2, bcd3, ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble correction step for one BCD nibble.
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_c_o
);
  assign nib_c_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with saturation at MAX_VAL.
// Define BIN2BCD_LEADING_BLANK_EN to blank leading zero digits with 4'hF.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W   = 14,  // must be >= 14
  parameter int unsigned MAX_VAL = DEFAULT_MAX_VAL
) (
  input  logic            clk,
  input  logic            rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(BIN_W);
  localparam int unsigned      NIB_BITS = BCD_DIGITS * NIB_W;
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [NIB_BITS-1:0] nib_q, nib_add, nib_d;
  logic [BIN_W-1:0]    opd_q, opd_d;
  logic                sat_q;
  bcd_t                out_q, res_c;
  logic                ovf_q;
  logic                carry_unused;
  logic                accept_c;
  logic                last_c;

  assign accept_c = (state_q == IDLE) && bus.start;
  assign last_c   = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  // State register with registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_c)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags decoded from the next state so they register in step with it
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d != IDLE) busy_d = 1'b1;
    if (state_d == DONE) done_d = 1'b1;
  end

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .nib_i   (nib_q[g*NIB_W +: NIB_W]),
      .nib_c_o (nib_add[g*NIB_W +: NIB_W])
    );
  end

  // Carry out of the thousands nibble is dropped; saturation covers that range
  assign {carry_unused, nib_d, opd_d} = {nib_add, opd_q, 1'b0};

  always_comb begin
    res_c = bcd_t'(nib_d);
    if (sat_q) res_c = bcd_t'({BCD_DIGITS{4'd9}});
`ifdef BIN2BCD_LEADING_BLANK_EN
    res_c = blank_leading(res_c);
`endif
  end

  // Working register, shift counter and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      nib_q <= '0;
      opd_q <= '0;
      sat_q <= 1'b0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept_c) begin
      cnt_q <= '0;
      nib_q <= '0;
      opd_q <= bus.bin;
      sat_q <= (bus.bin > MAX_BIN);
    end else if (state_q == SHIFT) begin
      nib_q <= nib_d;
      opd_q <= opd_d;
      if (last_c) begin
        out_q <= res_c;
        ovf_q <= sat_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd0 = out_q.d0;
  assign bus.bcd1 = out_q.d1;
  assign bus.bcd2 = out_q.d2;
  assign bus.bcd3 = out_q.d3;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: the driver queues decimal expectations,
// the monitor checks every done pulse and that results hold between pulses.
module tb_bin_to_bcd_seq;

  localparam int unsigned BIN_W   = 14;
  localparam int unsigned MAX_VAL = 9999;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  exp_t held;
  logic prev_done;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(MAX_VAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decimal digits of the displayed value, computed arithmetically
  function automatic exp_t model(int unsigned v);
    exp_t        e;
    int unsigned x;
    e.ovf = (v > MAX_VAL);
    x     = e.ovf ? 9999 : v;
    e.d3  = 4'(x / 1000);
    e.d2  = 4'((x / 100) % 10);
    e.d1  = 4'((x / 10) % 10);
    e.d0  = 4'(x % 10);
`ifdef BIN2BCD_LEADING_BLANK_EN
    if (x < 1000) e.d3 = 4'hF;
    if (x < 100)  e.d2 = 4'hF;
    if (x < 10)   e.d1 = 4'hF;
`endif
    return e;
  endfunction

  function automatic exp_t dut_out();
    return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0, bus.ovf};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop one expectation per done pulse, otherwise results must hold
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_done = 1'b0;
      held      = '0;
    end else begin
      if (bus.done) begin
        chk("done_single_cycle", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with out=%h, required no done (cycle %0d)",
                   dut_out(), cyc);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(dut_out()), 32'(e));
          chk("busy_in_done", 32'(bus.busy), 32'd1);
          held = e;
        end
      end else begin
        chk("hold_stable", 32'(dut_out()), 32'(held));
      end
      prev_done = bus.done;
    end
  end

  // Issue one conversion from a negedge once the block is idle
  task automatic convert(input int unsigned v);
    int t = 0;
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait_timeout", 32'(t >= 100), 32'd0);
    bus.start = 1'b1;
    bus.bin   = BIN_W'(v);
    exp_q.push_back(model(v));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    int acc;
    int last_acc;
    int t;
    int unsigned dir_vals[6] = '{1234, 9999, 10000, 16383, 5, 42};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_out", 32'(dut_out()), 32'd0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    rst_n = 1'b1;

    // bin=0 and latency: start driven this cycle, done expected BIN_W+1 edges later
    bus.start = 1'b1;
    bus.bin   = '0;
    exp_q.push_back(model(0));
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        bus.start = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
      end
      if (bus.done) break;
    end
    chk("latency", 32'(n), 32'(BIN_W + 1));
    drain();

    foreach (dir_vals[i]) convert(dir_vals[i]);
    convert(0);
    drain();

    // Start pulse while busy is ignored; bin change mid-shift has no effect
    convert(321);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = BIN_W'(7);
    drain();
    repeat (BIN_W + 4) @(negedge clk);

    // start held high: back-to-back conversions every BIN_W+2 cycles
    bus.start = 1'b1;
    bus.bin   = BIN_W'($urandom_range(0, 16383));
    acc = 0;
    last_acc = -1;
    t = 0;
    while (acc < 4 && t < 200) begin
      if (!bus.busy) begin
        exp_q.push_back(model(32'(bus.bin)));
        if (last_acc >= 0) chk("restart_period", 32'(cyc - last_acc), 32'(BIN_W + 2));
        last_acc = cyc;
        acc++;
      end else begin
        bus.bin = BIN_W'($urandom_range(0, 16383));
      end
      @(negedge clk);
      t++;
    end
    bus.start = 1'b0;
    chk("continuous_timeout", 32'(acc), 32'd4);
    drain();

    // Reset in mid-conversion aborts with no done
    convert(4321);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_out", 32'(dut_out()), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    bus.start = 1'b1;
    bus.bin   = BIN_W'(77);
    exp_q.push_back(model(77));
    @(negedge clk);
    bus.start = 1'b0;
    chk("first_edge_accept", 32'(bus.busy), 32'd1);
    drain();

    // Random values with ignored start pulses and bin noise while busy
    for (int i = 0; i < 30; i++) begin
      int unsigned v;
      case ($urandom_range(0, 5))
        0:       v = $urandom_range(9990, 10010);
        1:       v = $urandom_range(0, 12);
        default: v = $urandom_range(0, 16383);
      endcase
      convert(v);
      for (int k = 0; k < int'($urandom_range(0, BIN_W)); k++) begin
        if (bus.busy) begin
          bus.start = 1'($urandom_range(0, 1));
          bus.bin   = BIN_W'($urandom_range(0, 16383));
        end
        @(negedge clk);
        bus.start = 1'b0;
      end
      bus.start = 1'b0;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
